tb_bank_sched: RTL and testbench
================================

Name: tb_bank_sched

Overview:
Controller for the four trellis-memory banks in the Viterbi decoder.
- Each cycle, writes the ACS survivor selection vector into the current write bank.
- Sequences the write and read address counters and rotates the bank roles every 2^ADDR_W cycles.
- Steers the read-bank outputs to the two traceback units (TBUs) and issues their sticky enables.
- Sits between the ACS selection register and the trellis memories / TBUs.

Parameters:
ADDR_W, 10, bank address width; bank depth = 2^ADDR_W
DATA_W, 8, survivor selection vector width (one bit per trellis state)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
enable  in  1  decoder run enable; low = restart block
sel_in  in  DATA_W  ACS selection vector for the current cycle
mem_addr_o  out  4*ADDR_W  bank addresses; bank A = [ADDR_W-1:0], then B, C, D
mem_wr_o  out  4  write strobes; bit0 = A, bit1 = B, bit2 = C, bit3 = D
mem_din_o  out  DATA_W  write data, common to all banks
mem_dout_i  in  4*DATA_W  bank read data (1-cycle read latency), same packing as mem_addr_o
tbu0_en, tbu1_en  out  1 each  TBU enables (sticky)
tbu0_sel, tbu1_sel  out  1 each  TBU input-select
tbu0_d0, tbu0_d1, tbu1_d0, tbu1_d1  out  DATA_W each  TBU survivor inputs
bank_o  out  2  current write-bank index
wrap_o  out  1  one-cycle pulse when the bank index advances

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-low. Every flop in the block has an async reset.
- Reset values:
  - wr_cnt = 0; rd_cnt = all-ones; bank = 0; bank_d1 = 0; bank_d2 = 0.
  - All outputs = 0.
- Counters:
  - enable = 0: wr_cnt <= 0, rd_cnt <= all-ones. bank holds.
  - enable = 1: wr_cnt increments, rd_cnt decrements. Both wrap modulo 2^ADDR_W.
- Bank rotation:
  - When wr_cnt == all-ones and enable = 1, bank <= bank+1 (mod 4) and wrap_o = 1 for the following cycle.
  - enable falling at the wrap cycle: the wrap does not occur.
- Address/strobe stage is registered (1-cycle latency from counters), decoded from bank b:
  - Write bank = b: addr = wr_cnt, wr = 1.
  - Read banks = b+1 and b-1 (mod 4): addr = rd_cnt, wr = 0.
  - Idle bank = b+2 (mod 4): addr = 0, wr = 0.
  - Exactly one mem_wr_o bit is set per cycle after the first post-reset edge. mem_wr_o = 0 during reset.
- mem_din_o <= sel_in (registered). It is aligned with the write address on the same cycle.
- Bank pipeline: bank_d1 <= bank, bank_d2 <= bank_d1. This matches the 1-cycle address register plus 1-cycle memory read.
- TBU steering (registered, keyed on bank_d2), listed as tbu0 (d0, d1), tbu1 (d0, d1), tbu0_sel / tbu1_sel:
  - 0: tbu0 (D, C), tbu1 (C, B), sel 0/1
  - 1: tbu0 (D, C), tbu1 (A, D), sel 1/0
  - 2: tbu0 (B, A), tbu1 (A, D), sel 0/1
  - 3: tbu0 (B, A), tbu1 (C, B), sel 1/0
- TBU enables:
  - tbu0_en sets on the first cycle bank_d2 == 2; tbu1_en sets on the first cycle bank_d2 == 3.
  - Both stay set until rst; enable does not clear them.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Nothing is preserved.
- bank_o = bank (registered state, no extra latency).

Decomposition:
- Shared package (viterbi_pkg): bank index typedef (2-bit), bank enum A/B/C/D = 0..3, the TBU steering table as a constant array.
- One natural sub-module: tb_addr_gen, containing the wr_cnt/rd_cnt counters, the bank register and the wrap logic.
- The top level holds the address decode, the bank delay pipeline and the TBU steering mux.

Test Plan:
1. Reset, then enable = 1 for 3 cycles (ADDR_W = 10):
   - wr_cnt = 0, 1, 2; rd_cnt = 1023, 1022, 1021.
   - mem_wr_o = 4'b0001 from cycle 1.
   - Bank A addr follows wr_cnt with 1-cycle lag; B and D follow rd_cnt; C addr = 0.
2. Run 1024 enabled cycles:
   - wrap_o pulses once; bank_o = 1.
   - Next cycle mem_wr_o = 4'b0010; A and C addr = rd_cnt; D addr = 0.
3. Run 4096 cycles:
   - bank_o sequence 0, 1, 2, 3, 0.
   - tbu0_en rises 2 cycles after bank becomes 2; tbu1_en rises 2 cycles after bank becomes 3.
   - Both enables stay high after bank returns to 0.
4. Drive distinct mem_dout_i (A = 8'hA0, B = 8'hB0, C = 8'hC0, D = 8'hD0) with bank_d2 = 1:
   - tbu0_d0 = D0, tbu0_d1 = C0, tbu1_d0 = A0, tbu1_d1 = D0.
   - tbu0_sel = 1, tbu1_sel = 0.
5. Drop enable at wr_cnt = 500 for 2 cycles:
   - wr_cnt = 0, rd_cnt = 1023; bank_o unchanged; no wrap_o.
   - On resume, counting restarts from 0.
6. Assert rst mid-run with bank = 3:
   - All outputs are 0 immediately (no clock needed), including tbu0_en and tbu1_en.
   - After release, behaviour repeats scenario 1.

Source files
------------

// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_pkg
// Description : Shared types and constants for the Viterbi trellis-memory
//               bank scheduler. Holds the bank index type, the bank names
//               and the traceback-unit steering table.
// Revision    : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

    localparam int C_NUM_BANKS = 4;

    typedef logic [1:0] bank_idx_t;

    typedef enum logic [1:0] {
        BANK_A = 2'd0,
        BANK_B = 2'd1,
        BANK_C = 2'd2,
        BANK_D = 2'd3
    } bank_e;

    // One routing entry: which read bank feeds each TBU input, plus selects.
    typedef struct packed {
        bank_e t0_d0;
        bank_e t0_d1;
        bank_e t1_d0;
        bank_e t1_d1;
        logic  t0_sel;
        logic  t1_sel;
    } tbu_route_t;

    // Indexed by the write-bank index delayed to line up with read data.
    localparam tbu_route_t C_TBU_ROUTE [C_NUM_BANKS] = '{
        '{BANK_D, BANK_C, BANK_C, BANK_B, 1'b0, 1'b1},
        '{BANK_D, BANK_C, BANK_A, BANK_D, 1'b1, 1'b0},
        '{BANK_B, BANK_A, BANK_A, BANK_D, 1'b0, 1'b1},
        '{BANK_B, BANK_A, BANK_C, BANK_B, 1'b1, 1'b0}
    };

endpackage
`default_nettype wire

// File: rtl/tb_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_gen
// Description : Write/read address counters and bank rotation for the
//               trellis memories. The write counter counts up, the read
//               counter counts down; the bank index advances when the write
//               counter wraps while enabled.
// Ports       : clk, rst (async active-low), enable (low restarts block)
//               wr_cnt / rd_cnt - current write / read addresses
//               bank            - current write-bank index
//               wrap            - one-cycle pulse coincident with bank advance
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_gen
    import viterbi_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] wr_cnt,
    output logic [ADDR_W-1:0] rd_cnt,
    output bank_idx_t         bank,
    output logic              wrap
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt <= '0;
            rd_cnt <= '1;
            bank   <= '0;
            wrap   <= 1'b0;
        end else if (enable) begin
            wr_cnt <= wr_cnt + 1'b1;
            rd_cnt <= rd_cnt - 1'b1;
            if (wr_cnt == '1) begin
                bank <= bank + 2'd1;
                wrap <= 1'b1;
            end else begin
                wrap <= 1'b0;
            end
        end else begin
            // Restart the block; the bank role assignment is kept.
            wr_cnt <= '0;
            rd_cnt <= '1;
            wrap   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tb_bank_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_bank_sched
// Description : Four-bank trellis-memory scheduler. Writes the ACS survivor
//               selection vector into the write bank, drives read addresses
//               to the two read banks, and steers read data to the two
//               traceback units with sticky enables.
// Ports       : clk, rst (async active-low), enable, sel_in
//               mem_addr_o / mem_wr_o / mem_din_o - bank A..D address/strobe/data
//               mem_dout_i                        - bank A..D read data
//               tbu{0,1}_en/_sel/_d0/_d1          - traceback unit inputs
//               bank_o, wrap_o                    - bank index and wrap pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_sched
    import viterbi_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [DATA_W-1:0]            sel_in,
    output logic [C_NUM_BANKS*ADDR_W-1:0] mem_addr_o,
    output logic [C_NUM_BANKS-1:0]       mem_wr_o,
    output logic [DATA_W-1:0]            mem_din_o,
    input  logic [C_NUM_BANKS*DATA_W-1:0] mem_dout_i,
    output logic                         tbu0_en,
    output logic                         tbu1_en,
    output logic                         tbu0_sel,
    output logic                         tbu1_sel,
    output logic [DATA_W-1:0]            tbu0_d0,
    output logic [DATA_W-1:0]            tbu0_d1,
    output logic [DATA_W-1:0]            tbu1_d0,
    output logic [DATA_W-1:0]            tbu1_d1,
    output logic [1:0]                   bank_o,
    output logic                         wrap_o
);

    logic [ADDR_W-1:0] w_wr_cnt;
    logic [ADDR_W-1:0] w_rd_cnt;
    bank_idx_t         w_bank;
    logic              w_wrap;

    logic [ADDR_W-1:0] w_addr_nxt [C_NUM_BANKS];
    logic [C_NUM_BANKS-1:0] w_wr_nxt;
    logic [DATA_W-1:0] w_dout [C_NUM_BANKS];
    tbu_route_t        w_route;

    bank_idx_t         r_bank_d1;
    bank_idx_t         r_bank_d2;

    tb_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .wr_cnt (w_wr_cnt),
        .rd_cnt (w_rd_cnt),
        .bank   (w_bank),
        .wrap   (w_wrap)
    );

    assign bank_o = w_bank;
    assign wrap_o = w_wrap;

    // Role of each bank relative to the write bank b:
    // offset 0 = write, offset 1 or 3 = read, offset 2 = idle.
    always_comb begin
        for (int i = 0; i < C_NUM_BANKS; i++) begin
            w_addr_nxt[i] = '0;
            w_wr_nxt[i]   = 1'b0;
            case (bank_idx_t'(i[1:0] - w_bank))
                2'd0: begin
                    w_addr_nxt[i] = w_wr_cnt;
                    w_wr_nxt[i]   = 1'b1;
                end
                2'd2: w_addr_nxt[i] = '0;
                default: w_addr_nxt[i] = w_rd_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_o <= '0;
            mem_wr_o   <= '0;
            mem_din_o  <= '0;
        end else begin
            for (int i = 0; i < C_NUM_BANKS; i++) begin
                mem_addr_o[i*ADDR_W +: ADDR_W] <= w_addr_nxt[i];
            end
            mem_wr_o  <= w_wr_nxt;
            mem_din_o <= sel_in;
        end
    end

    for (genvar g = 0; g < C_NUM_BANKS; g++) begin : g_dout
        assign w_dout[g] = mem_dout_i[g*DATA_W +: DATA_W];
    end

    // Two-stage delay covers the address register plus the memory read, so
    // the steering key describes the bank layout that produced mem_dout_i.
    assign w_route = C_TBU_ROUTE[r_bank_d2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bank_d1 <= '0;
            r_bank_d2 <= '0;
            tbu0_en   <= 1'b0;
            tbu1_en   <= 1'b0;
            tbu0_sel  <= 1'b0;
            tbu1_sel  <= 1'b0;
            tbu0_d0   <= '0;
            tbu0_d1   <= '0;
            tbu1_d0   <= '0;
            tbu1_d1   <= '0;
        end else begin
            r_bank_d1 <= w_bank;
            r_bank_d2 <= r_bank_d1;
            // Enables rise in the same cycle r_bank_d2 first takes the value.
            if (r_bank_d1 == bank_idx_t'(BANK_C)) tbu0_en <= 1'b1;
            if (r_bank_d1 == bank_idx_t'(BANK_D)) tbu1_en <= 1'b1;
            tbu0_sel <= w_route.t0_sel;
            tbu1_sel <= w_route.t1_sel;
            tbu0_d0  <= w_dout[w_route.t0_d0];
            tbu0_d1  <= w_dout[w_route.t0_d1];
            tbu1_d0  <= w_dout[w_route.t1_d0];
            tbu1_d1  <= w_dout[w_route.t1_d1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tb_bank_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_tb_bank_sched
// Description : Self-checking bench for tb_bank_sched. A cycle-level model
//               tracks block position, bank index, bank history and the TBU
//               routing table, and each scenario task compares the design's
//               outputs against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tb_bank_sched;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  enable = 1'b0;
    logic [DATA_W-1:0]     sel_in = '0;
    logic [4*ADDR_W-1:0]   mem_addr_o;
    logic [3:0]            mem_wr_o;
    logic [DATA_W-1:0]     mem_din_o;
    logic [4*DATA_W-1:0]   mem_dout_i = '0;
    logic                  tbu0_en, tbu1_en, tbu0_sel, tbu1_sel;
    logic [DATA_W-1:0]     tbu0_d0, tbu0_d1, tbu1_d0, tbu1_d1;
    logic [1:0]            bank_o;
    logic                  wrap_o;

    int checks   = 0;
    int failures = 0;

    tb_bank_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .enable     (enable),
        .sel_in     (sel_in),
        .mem_addr_o (mem_addr_o),
        .mem_wr_o   (mem_wr_o),
        .mem_din_o  (mem_din_o),
        .mem_dout_i (mem_dout_i),
        .tbu0_en    (tbu0_en),
        .tbu1_en    (tbu1_en),
        .tbu0_sel   (tbu0_sel),
        .tbu1_sel   (tbu1_sel),
        .tbu0_d0    (tbu0_d0),
        .tbu0_d1    (tbu0_d1),
        .tbu1_d0    (tbu1_d0),
        .tbu1_d1    (tbu1_d1),
        .bank_o     (bank_o),
        .wrap_o     (wrap_o)
    );

    always #5 clk = ~clk;

    // Routing table, bank numbers A=0..D=3, indexed by delayed bank.
    int R_T0D0 [4] = '{3, 3, 1, 1};
    int R_T0D1 [4] = '{2, 2, 0, 0};
    int R_T1D0 [4] = '{2, 0, 0, 2};
    int R_T1D1 [4] = '{1, 3, 3, 1};
    bit R_S0   [4] = '{0, 1, 0, 1};
    bit R_S1   [4] = '{1, 0, 1, 0};

    // Model state: position within block, bank index and its history.
    int  m_wr, m_bank, m_d1, m_d2, m_key;
    bit  m_wrap, m_en0, m_en1;
    bit  hold_dout = 0;
    logic [4*ADDR_W-1:0] e_addr;
    logic [3:0]          e_wr;
    logic [DATA_W-1:0]   e_din;
    logic [4*DATA_W+1:0] e_tbu;

    task automatic model_reset();
        m_wr = 0; m_bank = 0; m_d1 = 0; m_d2 = 0; m_key = 0;
        m_wrap = 0; m_en0 = 0; m_en1 = 0;
        e_addr = '0; e_wr = '0; e_din = '0; e_tbu = '0;
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then apply fresh random inputs away from the edge.
    task automatic step();
        @(posedge clk);
        for (int b = 0; b < 4; b++) begin
            int rel;
            rel = (b - m_bank + 4) % 4;
            if (rel == 0)      e_addr[b*ADDR_W +: ADDR_W] = ADDR_W'(m_wr);
            else if (rel == 2) e_addr[b*ADDR_W +: ADDR_W] = '0;
            else               e_addr[b*ADDR_W +: ADDR_W] = ADDR_W'(DEPTH - 1 - m_wr);
        end
        e_wr  = 4'(1 << m_bank);
        e_din = sel_in;
        m_key = m_d2;
        e_tbu = {mem_dout_i[R_T0D0[m_d2]*DATA_W +: DATA_W],
                 mem_dout_i[R_T0D1[m_d2]*DATA_W +: DATA_W],
                 mem_dout_i[R_T1D0[m_d2]*DATA_W +: DATA_W],
                 mem_dout_i[R_T1D1[m_d2]*DATA_W +: DATA_W],
                 R_S0[m_d2], R_S1[m_d2]};
        if (m_d1 == 2) m_en0 = 1;
        if (m_d1 == 3) m_en1 = 1;
        m_d2 = m_d1;
        m_d1 = m_bank;
        if (enable) begin
            m_wrap = (m_wr == DEPTH - 1);
            if (m_wrap) m_bank = (m_bank + 1) % 4;
            m_wr = (m_wr + 1) % DEPTH;
        end else begin
            m_wrap = 0;
            m_wr   = 0;
        end
        #1;
        sel_in = DATA_W'($urandom);
        if (!hold_dout) mem_dout_i = (4*DATA_W)'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_addr_o, mem_wr_o, mem_din_o, bank_o, wrap_o} !== '0) begin
            failures++;
            $display("FAIL reset_mem: addr=%h wr=%b din=%h bank=%0d wrap=%b, want all 0",
                     mem_addr_o, mem_wr_o, mem_din_o, bank_o, wrap_o);
        end
        checks++;
        if ({tbu0_en, tbu1_en, tbu0_sel, tbu1_sel, tbu0_d0, tbu0_d1, tbu1_d0, tbu1_d1} !== '0) begin
            failures++;
            $display("FAIL reset_tbu: en=%b%b sel=%b%b d=%h %h %h %h, want all 0",
                     tbu0_en, tbu1_en, tbu0_sel, tbu1_sel, tbu0_d0, tbu0_d1, tbu1_d0, tbu1_d1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_startup();
        enable = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (mem_wr_o !== 4'b0001) begin
                failures++;
                $display("FAIL startup_wr c%0d: got %b want 0001", c, mem_wr_o);
            end
            checks++;
            if (mem_addr_o !== e_addr || mem_din_o !== e_din) begin
                failures++;
                $display("FAIL startup_addr c%0d: got %h/%h want %h/%h", c, mem_addr_o, mem_din_o, e_addr, e_din);
            end
        end
        // Third edge registered wr_cnt=2, rd_cnt=DEPTH-3.
        checks++;
        if (mem_addr_o !== {ADDR_W'(DEPTH - 3), ADDR_W'(0), ADDR_W'(DEPTH - 3), ADDR_W'(2)}) begin
            failures++;
            $display("FAIL startup_abs: got %h want D=%0d C=0 B=%0d A=2", mem_addr_o, DEPTH - 3, DEPTH - 3);
        end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        int guard  = 0;
        while (m_bank == 0 && guard < 2 * DEPTH) begin
            step();
            guard++;
            if (wrap_o === 1'b1) pulses++;
            checks++;
            if (wrap_o !== m_wrap || bank_o !== 2'(m_bank)) begin
                failures++;
                $display("FAIL wrap_seq: wrap=%b bank=%0d want %b/%0d", wrap_o, bank_o, m_wrap, m_bank);
            end
        end
        checks++;
        if (pulses != 1 || bank_o !== 2'd1) begin
            failures++;
            $display("FAIL wrap_once: pulses=%0d bank=%0d want 1/1", pulses, bank_o);
        end
        step();
        checks++;
        if (mem_wr_o !== 4'b0010 || mem_addr_o[3*ADDR_W +: ADDR_W] !== '0 ||
            mem_addr_o[0 +: ADDR_W] !== e_addr[0 +: ADDR_W] ||
            mem_addr_o[2*ADDR_W +: ADDR_W] !== ADDR_W'(DEPTH - 1 - ((m_wr + DEPTH - 1) % DEPTH))) begin
            failures++;
            $display("FAIL wrap_roles: wr=%b addr=%h want wr=0010 addr=%h", mem_wr_o, mem_addr_o, e_addr);
        end
    endtask

    task automatic test_rotation();
        int t_b2 = -1, t_b3 = -1, t_e0 = -1, t_e1 = -1;
        logic [1:0] prev_bank;
        prev_bank = bank_o;
        for (int c = 0; c < 4 * DEPTH; c++) begin
            step();
            if (bank_o !== prev_bank) begin
                checks++;
                if (bank_o !== prev_bank + 2'd1) begin
                    failures++;
                    $display("FAIL rot_order: %0d -> %0d", prev_bank, bank_o);
                end
                if (bank_o === 2'd2 && t_b2 < 0) t_b2 = c;
                if (bank_o === 2'd3 && t_b3 < 0) t_b3 = c;
                prev_bank = bank_o;
            end
            if (tbu0_en === 1'b1 && t_e0 < 0) t_e0 = c;
            if (tbu1_en === 1'b1 && t_e1 < 0) t_e1 = c;
            checks++;
            if (bank_o !== 2'(m_bank) || wrap_o !== m_wrap || tbu0_en !== m_en0 || tbu1_en !== m_en1 ||
                mem_wr_o !== e_wr || mem_addr_o !== e_addr || mem_din_o !== e_din ||
                {tbu0_d0, tbu0_d1, tbu1_d0, tbu1_d1, tbu0_sel, tbu1_sel} !== e_tbu) begin
                failures++;
                $display("FAIL rot_cycle %0d: bank=%0d wrap=%b en=%b%b wr=%b addr=%h tbu=%h want %0d %b %b%b %b %h %h",
                         c, bank_o, wrap_o, tbu0_en, tbu1_en, mem_wr_o, mem_addr_o,
                         {tbu0_d0, tbu0_d1, tbu1_d0, tbu1_d1, tbu0_sel, tbu1_sel},
                         m_bank, m_wrap, m_en0, m_en1, e_wr, e_addr, e_tbu);
            end
        end
        checks++;
        if (t_b2 < 0 || t_e0 - t_b2 != 2 || t_b3 < 0 || t_e1 - t_b3 != 2) begin
            failures++;
            $display("FAIL en_delay: en0-bank2=%0d en1-bank3=%0d want 2/2", t_e0 - t_b2, t_e1 - t_b3);
        end
        checks++;
        if (tbu0_en !== 1'b1 || tbu1_en !== 1'b1) begin
            failures++;
            $display("FAIL en_sticky: en=%b%b want 11", tbu0_en, tbu1_en);
        end
    endtask

    task automatic test_steering();
        int guard = 0;
        hold_dout  = 1;
        mem_dout_i = {8'hD0, 8'hC0, 8'hB0, 8'hA0};
        step();
        while (m_key != 1 && guard < 5 * DEPTH) begin
            step();
            guard++;
        end
        checks++;
        if (m_key != 1) begin
            failures++;
            $display("FAIL steer_wait: bank_d2=1 not reached, got key %0d", m_key);
        end else if ({tbu0_d0, tbu0_d1, tbu1_d0, tbu1_d1} !== 32'hD0C0A0D0 ||
                     tbu0_sel !== 1'b1 || tbu1_sel !== 1'b0) begin
            failures++;
            $display("FAIL steer_b1: d=%h %h %h %h sel=%b%b want D0 C0 A0 D0 sel=10",
                     tbu0_d0, tbu0_d1, tbu1_d0, tbu1_d1, tbu0_sel, tbu1_sel);
        end
        hold_dout = 0;
    endtask

    task automatic test_enable_drop();
        int guard = 0;
        logic [1:0] b_save;
        while (m_wr != 500 && guard < 2 * DEPTH) begin step(); guard++; end
        b_save = bank_o;
        enable = 1'b0;
        repeat (2) begin
            step();
            checks++;
            if (bank_o !== b_save || wrap_o !== 1'b0) begin
                failures++;
                $display("FAIL drop_hold: bank=%0d wrap=%b want %0d/0", bank_o, wrap_o, b_save);
            end
        end
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (mem_addr_o[b_save*ADDR_W +: ADDR_W] !== ADDR_W'(k) ||
                mem_addr_o[(b_save+2'd1)*ADDR_W +: ADDR_W] !== ADDR_W'(DEPTH - 1 - k) ||
                mem_addr_o !== e_addr) begin
                failures++;
                $display("FAIL drop_restart k%0d: addr=%h want wr=%0d rd=%0d", k, mem_addr_o, k, DEPTH - 1 - k);
            end
        end
        // Dropping enable exactly on the wrap cycle must suppress the wrap.
        guard = 0;
        while (m_wr != DEPTH - 1 && guard < 2 * DEPTH) begin step(); guard++; end
        b_save = bank_o;
        enable = 1'b0;
        step();
        checks++;
        if (bank_o !== b_save || wrap_o !== 1'b0) begin
            failures++;
            $display("FAIL drop_at_wrap: bank=%0d wrap=%b want %0d/0", bank_o, wrap_o, b_save);
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_midrun();
        int guard = 0;
        while (m_bank != 3 && guard < 5 * DEPTH) begin step(); guard++; end
        checks++;
        if (bank_o !== 2'd3 || tbu0_en !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre: bank=%0d en0=%b want 3/1", bank_o, tbu0_en);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_addr_o, mem_wr_o, mem_din_o, bank_o, wrap_o, tbu0_en, tbu1_en, tbu0_sel, tbu1_sel,
             tbu0_d0, tbu0_d1, tbu1_d0, tbu1_d1} !== '0) begin
            failures++;
            $display("FAIL midrun_async: addr=%h wr=%b bank=%0d en=%b%b, want all 0",
                     mem_addr_o, mem_wr_o, bank_o, tbu0_en, tbu1_en);
        end
        model_reset();
        enable = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        test_startup();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_startup();
        test_wrap();
        test_rotation();
        test_steering();
        test_enable_drop();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
